mac_tx_arbiter: RTL and testbench

- Shares the single MAC transmit datapath between the ARP and IP senders.
- Grants one requester at a time and forwards its byte stream (type, data, valid, last) to the MAC TX framer with one registered stage.
- Enforces an inter-frame gap before the next grant.
- Sits between the ARP/IP layers and MAC_TX, mirroring the type-based demux on the receive side.

---
 rtl/mac_pkg.sv | 30 +++
 rtl/arb_2to1_pick.sv | 57 +++++
 rtl/mac_tx_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC transmit arbiter.
package mac_pkg;

    localparam int unsigned TYPE_W    = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned GAP_CNT_W = 8;
    localparam int unsigned TMO_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic OWN_ARP = 1'b0;
    localparam logic OWN_IP  = 1'b1;

    localparam logic [TYPE_W-1:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [TYPE_W-1:0] ETH_TYPE_ARP  = 16'h0806;

    // One byte beat offered by a requester.
    typedef struct packed {
        logic [TYPE_W-1:0] etype;
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              last;
    } tx_beat_t;

endpackage

// File: rtl/arb_2to1_pick.sv
// Two-way winner selection for the MAC TX arbiter.
// MAC_TX_ARB_RR_EN defined: round-robin with a preference register; otherwise fixed priority.
module arb_2to1_pick
    import mac_pkg::*;
#(
    parameter int unsigned P_ARP_PRIO = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic arp_req,
    input  logic ip_req,
    input  logic done,
    input  logic done_owner,
    output logic winner_c
);

`ifdef MAC_TX_ARB_RR_EN
    // Requester that wins the next tie; flips away from whoever was just served.
    logic pref_q;
    logic unused_c;

    assign unused_c = ^{1'b0, 32'(P_ARP_PRIO)};

    always_ff @(posedge clk) begin
        if (rst) begin
            pref_q <= OWN_ARP;
        end else if (done) begin
            pref_q <= ~done_owner;
        end
    end

    always_comb begin
        winner_c = OWN_ARP;
        if (arp_req && ip_req) begin
            winner_c = pref_q;
        end else if (ip_req) begin
            winner_c = OWN_IP;
        end
    end
`else
    localparam logic TIE_WINNER = (P_ARP_PRIO != 0) ? OWN_ARP : OWN_IP;

    logic unused_c;

    assign unused_c = ^{clk, rst, done, done_owner};

    always_comb begin
        winner_c = OWN_ARP;
        if (arp_req && ip_req) begin
            winner_c = TIE_WINNER;
        end else if (ip_req) begin
            winner_c = OWN_IP;
        end
    end
`endif

endmodule

// File: rtl/mac_tx_arbiter.sv
// Shares the MAC TX datapath between ARP and IP: grant, one registered forward stage, inter-frame gap.
// MAC_TX_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module mac_tx_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned P_IFG           = 12,
    parameter int unsigned P_GRANT_TIMEOUT = 64,
    parameter int unsigned P_ARP_PRIO      = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_arp_req,
    output logic              o_arp_grant,
    input  logic [TYPE_W-1:0] i_arp_type,
    input  logic [DATA_W-1:0] i_arp_data,
    input  logic              i_arp_valid,
    input  logic              i_arp_last,
    input  logic              i_ip_req,
    output logic              o_ip_grant,
    input  logic [TYPE_W-1:0] i_ip_type,
    input  logic [DATA_W-1:0] i_ip_data,
    input  logic              i_ip_valid,
    input  logic              i_ip_last,
    input  logic              i_mac_ready,
    output logic [TYPE_W-1:0] o_mac_type,
    output logic [DATA_W-1:0] o_mac_data,
    output logic              o_mac_valid,
    output logic              o_mac_last,
    output logic              o_owner,
    output logic              o_busy,
    output logic              o_timeout
);

    state_t               state_q;
    state_t               state_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q;
    logic [TMO_CNT_W-1:0] tmo_cnt_q;

    tx_beat_t beat_c;
    logic     winner_c;
    logic     grant_c;
    logic     tmo_hit_c;
    logic     gap_done_c;
    logic     frame_end_c;
    logic     pick_done_c;

    logic              arp_grant_d;
    logic              ip_grant_d;
    logic              owner_d;
    logic              busy_d;
    logic              timeout_d;
    logic              valid_d;
    logic              last_d;
    logic [DATA_W-1:0] data_d;
    logic [TYPE_W-1:0] type_d;

    // Only the current owner's stream is visible; the other requester is ignored entirely.
    always_comb begin
        if (o_owner == OWN_IP) begin
            beat_c = '{etype: i_ip_type, data: i_ip_data, valid: i_ip_valid, last: i_ip_last};
        end else begin
            beat_c = '{etype: i_arp_type, data: i_arp_data, valid: i_arp_valid, last: i_arp_last};
        end
    end

    assign grant_c     = (state_q == ST_IDLE) && i_mac_ready && (i_arp_req || i_ip_req);
    assign tmo_hit_c   = (state_q == ST_GRANT) && !beat_c.valid
                         && (tmo_cnt_q == TMO_CNT_W'(P_GRANT_TIMEOUT - 1));
    assign gap_done_c  = (state_q == ST_GAP) && (gap_cnt_q == GAP_CNT_W'(P_IFG - 1));
    assign frame_end_c = ((state_q == ST_GRANT) || (state_q == ST_XFER))
                         && beat_c.valid && beat_c.last;
    assign pick_done_c = frame_end_c || tmo_hit_c;

    arb_2to1_pick #(
        .P_ARP_PRIO(P_ARP_PRIO)
    ) u_pick (
        .clk       (i_clk),
        .rst       (i_rst),
        .arp_req   (i_arp_req),
        .ip_req    (i_ip_req),
        .done      (pick_done_c),
        .done_owner(o_owner),
        .winner_c  (winner_c)
    );

    // Counters restart whenever their state is not active, so they read zero on entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (state_q != ST_GAP) begin
                gap_cnt_q <= '0;
            end else if (gap_cnt_q != '1) begin
                gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
            end
            if (state_q != ST_GRANT) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (beat_c.valid) begin
                    state_d = beat_c.last ? ST_GAP : ST_XFER;
                end else if (tmo_hit_c) begin
                    state_d = ST_GAP;
                end
            end
            ST_XFER: begin
                if (frame_end_c) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        owner_d = o_owner;
        type_d  = o_mac_type;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d = winner_c;
                end
            end
            ST_GRANT: begin
                if (beat_c.valid) begin
                    type_d  = beat_c.etype;
                    data_d  = beat_c.data;
                    valid_d = 1'b1;
                    last_d  = beat_c.last;
                end
            end
            ST_XFER: begin
                data_d  = beat_c.data;
                valid_d = beat_c.valid;
                last_d  = beat_c.valid && beat_c.last;
            end
            default: ;
        endcase
        busy_d      = (state_d == ST_GRANT) || (state_d == ST_XFER);
        arp_grant_d = busy_d && (owner_d == OWN_ARP);
        ip_grant_d  = busy_d && (owner_d == OWN_IP);
        timeout_d   = tmo_hit_c;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_arp_grant <= 1'b0;
            o_ip_grant  <= 1'b0;
            o_owner     <= OWN_ARP;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
            o_mac_type  <= '0;
            o_mac_data  <= '0;
            o_mac_valid <= 1'b0;
            o_mac_last  <= 1'b0;
        end else begin
            o_arp_grant <= arp_grant_d;
            o_ip_grant  <= ip_grant_d;
            o_owner     <= owner_d;
            o_busy      <= busy_d;
            o_timeout   <= timeout_d;
            o_mac_type  <= type_d;
            o_mac_data  <= data_d;
            o_mac_valid <= valid_d;
            o_mac_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed self-checking bench for mac_tx_arbiter (default parameters).
module tb_mac_tx_arbiter;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_arp_req, i_arp_valid, i_arp_last;
    logic [15:0] i_arp_type;
    logic [7:0]  i_arp_data;
    logic        i_ip_req, i_ip_valid, i_ip_last;
    logic [15:0] i_ip_type;
    logic [7:0]  i_ip_data;
    logic        i_mac_ready;
    logic        o_arp_grant, o_ip_grant;
    logic [15:0] o_mac_type;
    logic [7:0]  o_mac_data;
    logic        o_mac_valid, o_mac_last, o_owner, o_busy, o_timeout;

    mac_tx_arbiter dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_arp_req  (i_arp_req),
        .o_arp_grant(o_arp_grant),
        .i_arp_type (i_arp_type),
        .i_arp_data (i_arp_data),
        .i_arp_valid(i_arp_valid),
        .i_arp_last (i_arp_last),
        .i_ip_req   (i_ip_req),
        .o_ip_grant (o_ip_grant),
        .i_ip_type  (i_ip_type),
        .i_ip_data  (i_ip_data),
        .i_ip_valid (i_ip_valid),
        .i_ip_last  (i_ip_last),
        .i_mac_ready(i_mac_ready),
        .o_mac_type (o_mac_type),
        .o_mac_data (o_mac_data),
        .o_mac_valid(o_mac_valid),
        .o_mac_last (o_mac_last),
        .o_owner    (o_owner),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Output monitor, sampled shortly after each rising edge.
    int          cyc = 0;
    logic [7:0]  mon_data[$];
    logic [15:0] mon_type[$];
    logic        mon_last[$];
    int          n_last = 0, n_tmo = 0;
    int          last_cyc = 0, tmo_cyc = 0, gnt_cyc_arp = 0, gnt_cyc_ip = 0;
    logic        gnt_at_last = 1'b0, prev_arp = 1'b0, prev_ip = 1'b0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (o_mac_valid) begin
            mon_data.push_back(o_mac_data);
            mon_type.push_back(o_mac_type);
            mon_last.push_back(o_mac_last);
        end
        if (o_mac_last) begin
            n_last++;
            last_cyc    = cyc;
            gnt_at_last = o_arp_grant | o_ip_grant;
        end
        if (o_arp_grant && !prev_arp) gnt_cyc_arp = cyc;
        if (o_ip_grant && !prev_ip) gnt_cyc_ip = cyc;
        if (o_timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
        prev_arp = o_arp_grant;
        prev_ip  = o_ip_grant;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit ip, input logic [15:0] t, input logic [7:0] d,
                         input logic v, input logic l);
        if (ip) begin
            i_ip_type = t; i_ip_data = d; i_ip_valid = v; i_ip_last = l;
        end else begin
            i_arp_type = t; i_arp_data = d; i_arp_valid = v; i_arp_last = l;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_arp_req = 1'b0; i_ip_req = 1'b0; i_mac_ready = 1'b0;
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
        drive(1'b1, 16'h0, 8'h0, 1'b0, 1'b0);
        repeat (3) tick();
        i_rst = 1'b0;
        mon_data.delete(); mon_type.delete(); mon_last.delete();
        n_last = 0; n_tmo = 0;
        tick();
    endtask

    // Wait for the grant, then stream n bytes base, base+1, ... with last on the final one.
    task automatic send_frame(input bit ip, input int n, input logic [15:0] t,
                              input logic [7:0] base, input bit drop_req);
        int w = 0;
        while (((ip ? o_ip_grant : o_arp_grant) == 1'b0) && w < 50) begin
            tick();
            w++;
        end
        check(ip ? "ip_grant_wait" : "arp_grant_wait", 32'(w < 50), 32'd1);
        if (w >= 50) return;
        for (int i = 0; i < n; i++) begin
            drive(ip, t, base + 8'(i), 1'b1, 1'(i == n - 1));
            if (drop_req) begin
                if (ip) i_ip_req = 1'b0;
                else i_arp_req = 1'b0;
            end
            tick();
            if (i == 0) check("lat1", 32'({o_mac_valid, o_mac_data}), 32'({1'b1, base}));
        end
        drive(ip, t, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int     errs, w, g0, arp_last;
        bit     who;
        bit [3:0] order;

        do_reset();
        check("rst_out", 32'({o_arp_grant, o_ip_grant, o_mac_valid, o_mac_last, o_busy,
                               o_timeout, o_owner, o_mac_type, o_mac_data}), 32'd0);

        // ARP only, 42-byte frame
        i_mac_ready = 1'b1;
        i_arp_req   = 1'b1;
        tick();
        check("arp_grant_lat", 32'(o_arp_grant), 32'd1);
        check("busy_owner", 32'({o_busy, o_owner}), 32'b10);
        send_frame(1'b0, 42, ETH_TYPE_ARP, 8'h10, 1'b1);
        check("grant_drop_at_last", 32'(gnt_at_last), 32'd0);
        repeat (4) tick();
        check("arp_beats", 32'(mon_data.size()), 32'd42);
        check("arp_last_cnt", 32'(n_last), 32'd1);
        errs = 0;
        for (int i = 0; i < 42; i++)
            if (mon_data[i] !== 8'h10 + 8'(i) || mon_type[i] !== ETH_TYPE_ARP
                || mon_last[i] !== 1'(i == 41)) errs++;
        check("arp_bytes", 32'(errs), 32'd0);
        check("type_hold", 32'(o_mac_type), 32'(ETH_TYPE_ARP));

        // Tie with fixed ARP priority; IP junk while ARP owns the MAC
        do_reset();
        i_mac_ready = 1'b1;
        i_arp_req = 1'b1; i_ip_req = 1'b1;
        drive(1'b1, 16'hBEEF, 8'hEE, 1'b1, 1'b0);
        tick();
        check("tie_arp_first", 32'({o_arp_grant, o_ip_grant}), 32'b10);
        send_frame(1'b0, 8, ETH_TYPE_ARP, 8'h40, 1'b1);
        arp_last = last_cyc;
        drive(1'b1, 16'h0, 8'h0, 1'b0, 1'b0);
        send_frame(1'b1, 6, ETH_TYPE_IPV4, 8'hA0, 1'b1);
        check("ip_after_gap", 32'(gnt_cyc_ip - arp_last), 32'd13);
        repeat (3) tick();
        check("tie_beats", 32'(mon_data.size()), 32'd14);
        errs = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                if (mon_data[i] !== 8'h40 + 8'(i) || mon_type[i] !== ETH_TYPE_ARP
                    || mon_last[i] !== 1'(i == 7)) errs++;
            end else begin
                if (mon_data[i] !== 8'hA0 + 8'(i - 8) || mon_type[i] !== ETH_TYPE_IPV4
                    || mon_last[i] !== 1'(i == 13)) errs++;
            end
        end
        check("tie_bytes", 32'(errs), 32'd0);

        // Both requesting continuously for 4 frames
        do_reset();
        i_mac_ready = 1'b1;
        i_arp_req = 1'b1; i_ip_req = 1'b1;
        order = '0;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!o_arp_grant && !o_ip_grant && w < 50) begin
                tick();
                w++;
            end
            who = o_ip_grant;
            order[k] = who;
            send_frame(who, 3, who ? ETH_TYPE_IPV4 : ETH_TYPE_ARP, 8'h60 + 8'(k * 4), 1'b0);
        end
        i_arp_req = 1'b0; i_ip_req = 1'b0;
`ifdef MAC_TX_ARB_RR_EN
        check("grant_order", 32'(order), 32'b1010);
`else
        check("grant_order", 32'(order), 32'b0000);
`endif
        check("order_lasts", 32'(n_last), 32'd4);

        // Grant timeout, then pending IP served with a single-beat frame
        do_reset();
        i_mac_ready = 1'b1;
        i_arp_req = 1'b1; i_ip_req = 1'b1;
        tick();
        check("tmo_grant", 32'(o_arp_grant), 32'd1);
        g0 = cyc;
        i_arp_req = 1'b0;
        w = 0;
        while (!o_timeout && w < 100) begin
            tick();
            w++;
        end
        check("tmo_seen", 32'(o_timeout), 32'd1);
        check("tmo_delay", 32'(cyc - g0), 32'd64);
        check("tmo_grant_drop", 32'({o_arp_grant, o_busy}), 32'd0);
        tick();
        check("tmo_pulse", 32'(o_timeout), 32'd0);
        send_frame(1'b1, 1, ETH_TYPE_IPV4, 8'hC5, 1'b1);
        check("tmo_ip_gap", 32'(gnt_cyc_ip - tmo_cyc), 32'd13);
        check("single_beat_grant", 32'(o_ip_grant), 32'd0);
        repeat (3) tick();
        check("tmo_count", 32'(n_tmo), 32'd1);
        check("single_beat", 32'({mon_data.size() == 1, mon_data[0], mon_last[0]}),
              32'({1'b1, 8'hC5, 1'b1}));

        // MAC not ready, then reset in the middle of a frame
        do_reset();
        i_arp_req = 1'b1;
        errs = 0;
        repeat (20) begin
            tick();
            if (o_arp_grant || o_busy) errs++;
        end
        check("no_grant_unready", 32'(errs), 32'd0);
        i_mac_ready = 1'b1;
        tick();
        check("grant_after_ready", 32'(o_arp_grant), 32'd1);
        for (int i = 0; i <= 10; i++) begin
            drive(1'b0, ETH_TYPE_ARP, 8'h80 + 8'(i), 1'b1, 1'b0);
            if (i == 10) i_rst = 1'b1;
            tick();
        end
        check("rst_mid_out", 32'({o_arp_grant, o_ip_grant, o_mac_valid, o_mac_last, o_busy,
                                   o_timeout, o_owner, o_mac_type, o_mac_data}), 32'd0);
        check("rst_partial_beats", 32'(mon_data.size()), 32'd10);
        check("rst_no_last", 32'(n_last), 32'd0);
        i_rst = 1'b0;
        drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
        tick();
        check("idle_after_rst", 32'(o_arp_grant), 32'd1);
        i_arp_req = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
